// File: rtl/blram_dp.sv
// True dual-port block RAM with byte enables, selectable read-during-write and an optional clear sequencer.
// Define BLRAM_OUTREG_EN to add a second output register stage per port (read latency 2).
module blram_dp #(
  parameter int SIZE         = 14,
  parameter int DEPTH        = 2**SIZE,
  parameter int WIDTH        = 32,
  parameter int RDW_MODE     = 0,
  parameter int CLEAR_ON_RST = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               a_we,
  input  logic [WIDTH/8-1:0] a_be,
  input  logic [SIZE-1:0]    a_addr,
  input  logic [WIDTH-1:0]   a_din,
  output logic [WIDTH-1:0]   a_dout,
  input  logic               b_we,
  input  logic [WIDTH/8-1:0] b_be,
  input  logic [SIZE-1:0]    b_addr,
  input  logic [WIDTH-1:0]   b_din,
  output logic [WIDTH-1:0]   b_dout,
  output logic               busy
);

  localparam int              NB      = WIDTH / 8;
  localparam logic [SIZE:0]   DEPTH_W = (SIZE+1)'(DEPTH);
  localparam logic [SIZE-1:0] LAST    = SIZE'(DEPTH - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  logic [WIDTH-1:0] mem [DEPTH];

  // Sequencer state is left visible by name (state_q, cnt_q) for checkers.
  state_e          state_q, state_d;
  logic [SIZE-1:0] cnt_q, cnt_d;
  logic            clr_we;

  logic            a_ok, b_ok, a_wr, b_wr;
  logic [WIDTH-1:0] a_old, b_old, a_mrg, b_mrg, a_rd, b_rd;
  logic [WIDTH-1:0] a_q1, b_q1;

  assign busy = (state_q == ST_CLEAR);

  // No handshake: each port takes one access per cycle unconditionally,
  // except while busy (writes dropped, read data forced to 0).
  assign a_ok = ({1'b0, a_addr} < DEPTH_W);
  assign b_ok = ({1'b0, b_addr} < DEPTH_W);
  assign a_wr = a_we && a_ok && !busy && !rst;
  assign b_wr = b_we && b_ok && !busy && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= (CLEAR_ON_RST != 0) ? ST_CLEAR : ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clr_we  = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        clr_we = 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + SIZE'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read paths see the array before this edge's writes; the merged word is
  // only used for same-port write-through.
  always_comb begin
    a_old = a_ok ? mem[a_addr] : '0;
    b_old = b_ok ? mem[b_addr] : '0;
    a_mrg = a_old;
    b_mrg = b_old;
    for (int i = 0; i < NB; i++) begin
      if (a_be[i]) a_mrg[8*i +: 8] = a_din[8*i +: 8];
      if (b_be[i]) b_mrg[8*i +: 8] = b_din[8*i +: 8];
    end
    a_rd = ((RDW_MODE == 1) && a_wr) ? a_mrg : a_old;
    b_rd = ((RDW_MODE == 1) && b_wr) ? b_mrg : b_old;
  end

  // Port A lanes are written after port B lanes so A wins a shared lane.
  always_ff @(posedge clk) begin
    if (clr_we && !rst) mem[cnt_q] <= '0;
    for (int i = 0; i < NB; i++) begin
      if (b_wr && b_be[i]) mem[b_addr][8*i +: 8] <= b_din[8*i +: 8];
      if (a_wr && a_be[i]) mem[a_addr][8*i +: 8] <= a_din[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || busy) begin
      a_q1 <= '0;
      b_q1 <= '0;
    end else begin
      a_q1 <= a_rd;
      b_q1 <= b_rd;
    end
  end

`ifdef BLRAM_OUTREG_EN
  logic [WIDTH-1:0] a_q2, b_q2;

  always_ff @(posedge clk) begin
    if (rst || busy) begin
      a_q2 <= '0;
      b_q2 <= '0;
    end else begin
      a_q2 <= a_q1;
      b_q2 <= b_q1;
    end
  end

  assign a_dout = a_q2;
  assign b_dout = b_q2;
`else
  assign a_dout = a_q1;
  assign b_dout = b_q1;
`endif

endmodule

// File: tb/tb_blram_dp.sv
// Directed bench for blram_dp: four instances cover RDW modes, the clear sequencer and out-of-range handling.
module tb_blram_dp;
`ifdef BLRAM_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [13:0] addr;
    logic [31:0] din;
  } port_t;

  logic        clk = 1'b0;
  port_t       pa [4];
  port_t       pb [4];
  logic [31:0] ad [4];
  logic [31:0] bd [4];
  logic        busy [4];
  logic        rst [4];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] exp_q[$];
  int          due_q[$];
  int          sel_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  blram_dp #(.RDW_MODE(0)) d0 (
    .clk(clk), .rst(rst[0]),
    .a_we(pa[0].we), .a_be(pa[0].be), .a_addr(pa[0].addr), .a_din(pa[0].din), .a_dout(ad[0]),
    .b_we(pb[0].we), .b_be(pb[0].be), .b_addr(pb[0].addr), .b_din(pb[0].din), .b_dout(bd[0]),
    .busy(busy[0]));

  blram_dp #(.RDW_MODE(1)) d1 (
    .clk(clk), .rst(rst[1]),
    .a_we(pa[1].we), .a_be(pa[1].be), .a_addr(pa[1].addr), .a_din(pa[1].din), .a_dout(ad[1]),
    .b_we(pb[1].we), .b_be(pb[1].be), .b_addr(pb[1].addr), .b_din(pb[1].din), .b_dout(bd[1]),
    .busy(busy[1]));

  blram_dp #(.SIZE(4), .DEPTH(16), .CLEAR_ON_RST(1)) d2 (
    .clk(clk), .rst(rst[2]),
    .a_we(pa[2].we), .a_be(pa[2].be), .a_addr(pa[2].addr[3:0]), .a_din(pa[2].din), .a_dout(ad[2]),
    .b_we(pb[2].we), .b_be(pb[2].be), .b_addr(pb[2].addr[3:0]), .b_din(pb[2].din), .b_dout(bd[2]),
    .busy(busy[2]));

  blram_dp #(.SIZE(4), .DEPTH(12)) d3 (
    .clk(clk), .rst(rst[3]),
    .a_we(pa[3].we), .a_be(pa[3].be), .a_addr(pa[3].addr[3:0]), .a_din(pa[3].din), .a_dout(ad[3]),
    .b_we(pb[3].we), .b_be(pb[3].be), .b_addr(pb[3].addr[3:0]), .b_din(pb[3].din), .b_dout(bd[3]),
    .busy(busy[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // sel = 2*instance + port (0 = A, 1 = B)
  function automatic logic [31:0] dout_of(input int sel);
    return (sel % 2 == 1) ? bd[sel / 2] : ad[sel / 2];
  endfunction

  task automatic expect_rd(input int sel, input logic [31:0] e, input string tag);
    exp_q.push_back(e);
    due_q.push_back(cyc + LAT);
    sel_q.push_back(sel);
    tag_q.push_back(tag);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    while (due_q.size() > 0 && due_q[0] <= cyc) begin
      logic [31:0] e;
      int          s;
      string       t;
      e = exp_q.pop_front();
      s = sel_q.pop_front();
      t = tag_q.pop_front();
      void'(due_q.pop_front());
      chk(t, dout_of(s), e);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < LAT + 1 && due_q.size() > 0; i++) step();
    chk("sb_empty", 32'(due_q.size()), 32'd0);
  endtask

  task automatic set_a(input int k, input logic we, input logic [3:0] be,
                       input logic [13:0] addr, input logic [31:0] din);
    pa[k] = {we, be, addr, din};
  endtask

  task automatic set_b(input int k, input logic we, input logic [3:0] be,
                       input logic [13:0] addr, input logic [31:0] din);
    pb[k] = {we, be, addr, din};
  endtask

  // Counts busy cycles of d2 from the current sample; checks hold-at-zero on B.
  task automatic count_busy(input string tag);
    int n;
    n = 0;
    while (busy[2] === 1'b1 && n < 100) begin
      chk("clr_hold_b", bd[2], 32'd0);
      n++;
      step();
    end
    chk(tag, 32'(n), 32'd16);
  endtask

  initial begin
    int n;
    for (int k = 0; k < 4; k++) begin
      pa[k]  = '0;
      pb[k]  = '0;
      rst[k] = 1'b1;
    end
    @(negedge clk);
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      chk("rst_a_dout", ad[k], 32'd0);
      chk("rst_b_dout", bd[k], 32'd0);
    end
    chk("rst_busy_clr", 32'(busy[2]), 32'd1);
    chk("rst_busy_noclr", 32'(busy[0]), 32'd0);
    for (int k = 0; k < 4; k++) rst[k] = 1'b0;

    n = 0;
    while (busy[2] === 1'b1 && n < 100) begin
      n++;
      step();
    end
    chk("init_clear_len", 32'(n), 32'd16);

    // basic write on A, read on B
    set_a(0, 1'b1, 4'hF, 14'd100, 32'd5);
    step();
    set_a(0, 1'b0, 4'h0, 14'd100, 32'd0);
    set_b(0, 1'b0, 4'h0, 14'd100, 32'd0);
    expect_rd(1, 32'd5, "basic_b");
    step();
    drain();

    // byte enables
    d0.mem[101] = 32'hFFFF_FFFF;
    set_a(0, 1'b1, 4'b0101, 14'd101, 32'h1234_5678);
    step();
    set_a(0, 1'b0, 4'h0, 14'd101, 32'd0);
    expect_rd(0, 32'hFF34_FF78, "byte_en");
    step();
    drain();

    // same-port read-during-write, both modes
    d0.mem[102] = 32'd16;
    d1.mem[102] = 32'd16;
    set_a(0, 1'b1, 4'hF, 14'd102, 32'd8);
    set_a(1, 1'b1, 4'hF, 14'd102, 32'd8);
    expect_rd(0, 32'd16, "rdw_old");
    expect_rd(2, 32'd8, "rdw_thru");
    step();
    set_a(0, 1'b0, 4'h0, 14'd102, 32'd0);
    set_a(1, 1'b0, 4'h0, 14'd102, 32'd0);
    expect_rd(0, 32'd8, "rdw_old_next");
    expect_rd(2, 32'd8, "rdw_thru_next");
    step();
    drain();

    // both ports write one address: per-lane resolution
    set_a(0, 1'b1, 4'b1100, 14'd110, 32'hAAAA_AAAA);
    set_b(0, 1'b1, 4'hF, 14'd110, 32'h5555_5555);
    step();
    set_a(0, 1'b0, 4'h0, 14'd110, 32'd0);
    set_b(0, 1'b0, 4'h0, 14'd110, 32'd0);
    expect_rd(0, 32'hAAAA_5555, "collide_a");
    expect_rd(1, 32'hAAAA_5555, "collide_b");
    step();
    drain();

    // cross-port: B reads while A writes the same word
    d0.mem[111] = 32'h0BAD_F00D;
    set_a(0, 1'b1, 4'hF, 14'd111, 32'h1234_0000);
    set_b(0, 1'b0, 4'h0, 14'd111, 32'd0);
    expect_rd(1, 32'h0BAD_F00D, "cross_old");
    step();
    set_a(0, 1'b0, 4'h0, 14'd111, 32'd0);
    expect_rd(1, 32'h1234_0000, "cross_new");
    step();
    drain();

    // clear sequencer with a write attempted throughout busy
    for (int i = 0; i < 16; i++) d2.mem[i] = 32'hDEAD_BEEF;
    set_b(2, 1'b0, 4'h0, 14'd5, 32'd0);
    set_a(2, 1'b1, 4'hF, 14'd0, 32'h1234_5678);
    rst[2] = 1'b1;
    step();
    rst[2] = 1'b0;
    count_busy("clr_busy_len");
    set_a(2, 1'b0, 4'h0, 14'd0, 32'd0);
    for (int i = 0; i < 16; i++) begin
      set_a(2, 1'b0, 4'h0, 14'(i), 32'd0);
      expect_rd(4, 32'd0, "clr_word");
      step();
    end
    drain();

    // reset again at clear cycle 8
    for (int i = 0; i < 16; i++) d2.mem[i] = 32'hDEAD_BEEF;
    rst[2] = 1'b1;
    step();
    rst[2] = 1'b0;
    repeat (8) step();
    rst[2] = 1'b1;
    step();
    rst[2] = 1'b0;
    count_busy("clr_restart_len");
    for (int i = 0; i < 16; i++) begin
      set_b(2, 1'b0, 4'h0, 14'(15 - i), 32'd0);
      expect_rd(5, 32'd0, "clr_restart_word");
      step();
    end
    drain();

    // out-of-range write and reads
    for (int i = 0; i < 12; i++) d3.mem[i] = 32'h1000_0000 + 32'(i) * 32'h0101;
    set_a(3, 1'b1, 4'hF, 14'd13, 32'h1);
    step();
    set_a(3, 1'b0, 4'h0, 14'd13, 32'd0);
    set_b(3, 1'b0, 4'h0, 14'd12, 32'd0);
    expect_rd(6, 32'd0, "oor_read13");
    expect_rd(7, 32'd0, "oor_read12");
    step();
    for (int i = 0; i < 12; i++) begin
      set_a(3, 1'b0, 4'h0, 14'(i), 32'd0);
      expect_rd(6, 32'h1000_0000 + 32'(i) * 32'h0101, "oor_keep");
      step();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
